// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: sequences one register-file request at a time through
// IDLE -> (WRITE) -> (READ) -> RESP and holds the response until it is taken.
// Every output comes straight from a flop; next values are formed in one
// combinational block and captured in one clocked block.
module reg_access_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int R0_PROTECT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rd1,
  output logic [DATA_W-1:0] rsp_rd2,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_WR    = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsp_rd1_q, rsp_rd1_d, rsp_rd2_q, rsp_rd2_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rf_we_q, rf_we_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;

  // Next-state, request latching, response formation and registered-output decode
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    rsp_rd1_d = rsp_rd1_q;
    rsp_rd2_d = rsp_rd2_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          rs1_d     = req_rs1;
          rs2_d     = req_rs2;
          rd_d      = req_rd;
          wdata_d   = req_wdata;
          rsp_rd1_d = {DATA_W{1'b0}};
          rsp_rd2_d = {DATA_W{1'b0}};
          rsp_err_d = 1'b0;
          case (req_op)
            OP_READ:         state_d = S_READ;
            OP_WRITE, OP_WR: state_d = S_WRITE;
            default: begin
              // Illegal op: straight to response with the error flag, data zero
              state_d   = S_RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (op_q == OP_WR) begin
          state_d = S_READ;
        end else begin
          // Plain write echoes the written data back as the response
          state_d   = S_RESP;
          rsp_rd1_d = wdata_q;
          rsp_rd2_d = {DATA_W{1'b0}};
        end
      end
      S_READ: begin
        // Register file reads are asynchronous, so the write of the previous
        // cycle (if any) is already visible here
        rsp_rd1_d = rf_rd1;
        rsp_rd2_d = rf_rd2;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with it
    rf_we_d     = (state_d == S_WRITE) &&
                  !((R0_PROTECT != 0) && (rd_d == {ADDR_W{1'b0}}));
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      rs1_q       <= {ADDR_W{1'b0}};
      rs2_q       <= {ADDR_W{1'b0}};
      rd_q        <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rsp_rd1_q   <= {DATA_W{1'b0}};
      rsp_rd2_q   <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      rsp_rd1_q   <= rsp_rd1_d;
      rsp_rd2_q   <= rsp_rd2_d;
      rsp_err_q   <= rsp_err_d;
      rf_we_q     <= rf_we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd1   = rsp_rd1_q;
  assign rsp_rd2   = rsp_rd2_q;
  assign rsp_err   = rsp_err_q;
  assign rf_a1     = rs1_q;
  assign rf_a2     = rs2_q;
  assign rf_a3     = rd_q;
  assign rf_wd3    = wdata_q;
  assign rf_we     = rf_we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl (R0_PROTECT=1): directed scenarios followed by
// random transactions, all checked against a transaction-level model of the
// register file and the per-op latency/response rules.
module tb_reg_access_ctrl;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int PROT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_rs1, req_rs2, req_rd;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rd1, rsp_rd2;
  logic          rsp_err;
  logic [AW-1:0] rf_a1, rf_a2, rf_a3;
  logic [DW-1:0] rf_wd3;
  logic          rf_we;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf_mem [8];
  logic [DW-1:0] mdl    [8];

  reg_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .R0_PROTECT(PROT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2), .rsp_err(rsp_err),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we(rf_we),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench register file: asynchronous read, write on rising edge, cleared by reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0000;
    end else if (rf_we) begin
      rf_mem[rf_a3] <= rf_wd3;
    end
  end
  assign rf_rd1 = rf_mem[rf_a1];
  assign rf_rd2 = rf_mem[rf_a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rf_we"},     rf_we, 0);
    chk({tag, "_rsp_rd1"},   rsp_rd1, 0);
    chk({tag, "_rsp_rd2"},   rsp_rd2, 0);
    chk({tag, "_rsp_err"},   rsp_err, 0);
    chk({tag, "_rf_a1"},     rf_a1, 0);
    chk({tag, "_rf_a2"},     rf_a2, 0);
    chk({tag, "_rf_a3"},     rf_a3, 0);
    chk({tag, "_rf_wd3"},    rf_wd3, 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
  endtask

  // One full request/response transaction; hold = cycles rsp_ready is kept low in RESP
  task automatic txn(input logic [1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                     input logic [AW-1:0] rd, input logic [DW-1:0] wd, input int hold);
    int            exp_lat, lat, we_cnt, exp_we;
    logic [DW-1:0] e1, e2;
    logic          ee;
    bit            seen;
    // Reference: apply the write first, then evaluate reads on the updated file
    exp_we = 0;
    if ((op == 2'b01 || op == 2'b10) && !(PROT != 0 && rd == 3'd0)) begin
      mdl[rd] = wd;
      exp_we  = 1;
    end
    case (op)
      2'b00:   begin exp_lat = 2; e1 = mdl[rs1]; e2 = mdl[rs2]; ee = 1'b0; end
      2'b01:   begin exp_lat = 2; e1 = wd;       e2 = 16'h0000; ee = 1'b0; end
      2'b10:   begin exp_lat = 3; e1 = mdl[rs1]; e2 = mdl[rs2]; ee = 1'b0; end
      default: begin exp_lat = 1; e1 = 16'h0000; e2 = 16'h0000; ee = 1'b1; end
    endcase

    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble request fields after the handshake; they must be ignored
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_rs1   = 3'($urandom);
    req_rs2   = 3'($urandom);
    req_rd    = 3'($urandom);
    req_wdata = 16'($urandom);

    seen = 1'b0; lat = 0; we_cnt = 0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      if (rf_we) begin
        we_cnt++;
        chk("we_a3", rf_a3, rd);
        chk("we_wd3", rf_wd3, wd);
      end
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        chk("busy_in_flight", busy, 1);
        @(posedge clk); #1;
      end
    end
    chk("latency", lat, exp_lat);
    chk("we_pulses", we_cnt, exp_we);
    chk("rsp_rd1", rsp_rd1, e1);
    chk("rsp_rd2", rsp_rd2, e2);
    chk("rsp_err", rsp_err, ee);
    chk("ready_in_resp", req_ready, 0);

    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rd1", rsp_rd1, e1);
      chk("hold_rd2", rsp_rd2, e2);
      chk("hold_err", rsp_err, ee);
      chk("hold_ready", req_ready, 0);
      chk("hold_we", rf_we, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_ready", req_ready, 1);
    chk("idle_valid", rsp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_rs1 = 3'd0; req_rs2 = 3'd0;
    req_rd = 3'd0; req_wdata = 16'h0000; rsp_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Directed scenarios
    txn(2'b01, 3'd0, 3'd0, 3'd3, 16'hBEEF, 0);
    txn(2'b01, 3'd0, 3'd0, 3'd1, 16'h0011, 0);
    txn(2'b01, 3'd0, 3'd0, 3'd2, 16'h0022, 0);
    txn(2'b00, 3'd1, 3'd2, 3'd6, 16'h5555, 0);
    txn(2'b10, 3'd5, 3'd0, 3'd5, 16'h1234, 0);
    txn(2'b11, 3'd1, 3'd2, 3'd7, 16'hAAAA, 0);
    txn(2'b00, 3'd3, 3'd5, 3'd0, 16'h0000, 4);
    txn(2'b01, 3'd0, 3'd0, 3'd0, 16'hDEAD, 1);
    txn(2'b10, 3'd0, 3'd3, 3'd0, 16'hCAFE, 0);

    // Reset in the middle of a WRITE: pulse must end and not reappear
    chk("rstw_ready", req_ready, 1);
    req_valid = 1'b1; req_op = 2'b01; req_rd = 3'd4; req_wdata = 16'h7777;
    req_rs1 = 3'd4; req_rs2 = 3'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_we_in_write", rf_we, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    chk_reset_outputs("rst_in_write");
    @(posedge clk); #1;
    chk("rstw_no_retry_we", rf_we, 0);
    chk("rstw_still_idle", req_ready, 1);
    txn(2'b00, 3'd4, 3'd3, 3'd0, 16'h0000, 0);

    // Random transactions against the reference model
    for (int t = 0; t < 60; t++) begin
      txn(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom_range(0, 7)),
          16'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 SHALL have parameter R0_PROTECT, default 0; when 1, writes to address 0 are suppressed.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts request this cycle.
- req_op  input  2  00 READ, 01 WRITE, 10 WRITE_READ, 11 illegal.
- req_rs1, req_rs2  input  ADDR_W  read addresses.
- req_rd  input  ADDR_W  write address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_rd1, rsp_rd2  output  DATA_W  response data.
- rsp_err  output  1  illegal-op flag.
- rf_a1, rf_a2, rf_a3  output  ADDR_W  register-file addresses.
- rf_wd3  output  DATA_W  register-file write data.
- rf_we  output  1  register-file write enable.
- rf_rd1, rf_rd2  input  DATA_W  register-file asynchronous read data.
- busy  output  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid && req_ready.
REQ-007 On handshake SHALL latch op, rs1, rs2, rd and wdata; later changes on req_* SHALL have no effect until the next handshake.
REQ-008 After handshake, next state SHALL be: READ -> READ; WRITE or WRITE_READ -> WRITE; illegal -> RESP.
REQ-009 In WRITE, rf_we SHALL be 1 for exactly one cycle, with rf_a3 = latched rd and rf_wd3 = latched wdata.
REQ-010 If R0_PROTECT=1 and latched rd=0, rf_we SHALL stay 0 in WRITE; the FSM SHALL still traverse WRITE.
REQ-011 After WRITE, next state SHALL be READ for WRITE_READ and RESP for WRITE.
REQ-012 rf_we SHALL be 0 in every state except WRITE.
REQ-013 rf_a1 / rf_a2 SHALL equal latched rs1 / rs2 in all states; rf_a3 and rf_wd3 SHALL equal latched rd / wdata in all states.
REQ-014 In READ (one cycle), SHALL capture rf_rd1 / rf_rd2 into rsp_rd1 / rsp_rd2 on the clock edge, then go to RESP.
REQ-015 WRITE_READ SHALL return the post-write register values; read of rd returns the new wdata (unless suppressed by REQ-010).
REQ-016 WRITE-only response SHALL set rsp_rd1 = latched wdata and rsp_rd2 = 0, rsp_err = 0.
REQ-017 Illegal-op response SHALL set rsp_rd1 = rsp_rd2 = 0 and rsp_err = 1; no register-file write SHALL occur.
REQ-018 rsp_valid SHALL be 1 exactly in RESP; rsp_rd1, rsp_rd2 and rsp_err SHALL be stable while rsp_valid && !rsp_ready.
REQ-019 On rsp_valid && rsp_ready, SHALL return to IDLE; the next request can be accepted on the following cycle.
REQ-020 Latencies from handshake cycle to first rsp_valid cycle SHALL be:
- READ: 2 cycles
- WRITE: 2 cycles
- WRITE_READ: 3 cycles
- illegal: 1 cycle
REQ-021 rsp_err SHALL be 0 for all legal ops.

Reset
REQ-022 rst SHALL be synchronous and active-high; when asserted at a rising edge, it SHALL override all other activity, including mid-operation.
REQ-023 After reset: state IDLE; all latched fields, rsp_rd1, rsp_rd2 and rsp_err = 0; rf_we = 0; rsp_valid = 0; busy = 0; req_ready = 1.
REQ-024 Reset asserted during WRITE SHALL cause rf_we to be 0 from the following cycle, with no retried write.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- WRITE rd=3, wdata=16'hBEEF, rsp_ready=1 -> single rf_we pulse with a3=3; rsp_rd1=BEEF, rsp_rd2=0, rsp_err=0, two cycles after handshake.
- Preload r1=16'h0011, r2=16'h0022; READ rs1=1, rs2=2 -> rsp_rd1=0011, rsp_rd2=0022, two cycles after handshake.
- WRITE_READ rd=5, wdata=16'h1234, rs1=5, rs2=0 -> rsp_rd1=1234, rsp_rd2=r0 value, three cycles after handshake.
- req_op=11 -> rsp_err=1, data 0, rf_we never asserted, rsp_valid one cycle after handshake.
- rsp_ready held 0 for 4 cycles in RESP -> rsp_valid stays 1 with stable data, req_ready stays 0; on release, IDLE next cycle.
- R0_PROTECT=1, WRITE rd=0 -> rf_we stays 0, rsp returned normally; separately, rst during WRITE -> IDLE and all outputs at reset values next cycle.
